zcash_cmd_dispatch: RTL and testbench

Host-command front end for the FPGA control path. It accepts the 64-bit host-to-FPGA byte stream, parses the 8-byte command header, and handles two kinds of command:
- Local commands (RESET_FPGA, FPGA_STATUS) are answered here.
- Verification commands (VERIFY_EQUIHASH, VERIFY_SECP256K1_SIG) are forwarded whole to their engines.

Anything unrecognised is answered with FPGA_IGNORE_RPL. The block sits between the host interface and the equihash/secp256k1 engines and the reply arbiter.

---
 rtl/zcash_cmd_dispatch_pkg.sv | 112 +++++++++++
 rtl/zcash_rpl_serialiser.sv | 70 +++++++
 rtl/zcash_cmd_dispatch.sv | 244 ++++++++++++++++++++++++
 tb/tb_zcash_cmd_dispatch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zcash_cmd_dispatch_pkg.sv
// Shared types for the host command path: command codes, header layout, local reply
// structures and their builder functions, the command capability mask, and the width
// of the reply staging register.
package zcash_cmd_dispatch_pkg;

  typedef enum logic [31:0] {
    RESET_FPGA           = 32'h0000_0000,
    FPGA_STATUS          = 32'h0000_0001,
    VERIFY_EQUIHASH      = 32'h0000_0100,
    VERIFY_SECP256K1_SIG = 32'h0000_0101,
    RESET_FPGA_RPL       = 32'h8000_0000,
    FPGA_STATUS_RPL      = 32'h8000_0001,
    FPGA_IGNORE_RPL      = 32'h8000_0002
  } command_t;

  // len is in bytes and includes the 8-byte header itself.
  typedef struct packed {
    command_t    cmd;
    logic [31:0] len;
  } header_t;

  typedef logic [7:0] fpga_state_t;

  localparam int ENB_VERIFY_EQUIHASH_200_9 = 0;
  localparam int ENB_VERIFY_EQUIHASH_144_5 = 1;
  localparam int ENB_VERIFY_SECP256K1_SIG  = 8;

  localparam logic [63:0] FPGA_CMD_CAP = (64'd1 << ENB_VERIFY_EQUIHASH_200_9) |
                                         (64'd1 << ENB_VERIFY_EQUIHASH_144_5) |
                                         (64'd1 << ENB_VERIFY_SECP256K1_SIG);

  localparam logic [31:0] FPGA_VERSION = 32'h0001_0201;

  // Wide enough for the largest local reply, serialised 64 bits at a time.
  localparam int unsigned RplRegWidth = 384;

  typedef struct packed {
    header_t hdr;
  } fpga_reset_rpl_t;

  typedef struct packed {
    header_t ignore_hdr;
    header_t hdr;
  } fpga_ignore_rpl_t;

  // 37 bytes; the last field lands in byte 4 of the fifth word.
  typedef struct packed {
    fpga_state_t fpga_state;
    logic [63:0] build_date;
    logic [63:0] build_host;
    logic [63:0] cmd_cap;
    logic [31:0] version;
    header_t     hdr;
  } fpga_status_rpl_t;

  typedef enum logic [2:0] {
    RouteEq,
    RouteSecp,
    RouteReset,
    RouteStatus,
    RouteIgnore
  } route_e;

  function automatic fpga_reset_rpl_t get_fpga_reset_rpl();
    fpga_reset_rpl_t r;
    r.hdr.cmd = RESET_FPGA_RPL;
    r.hdr.len = 32'($bits(fpga_reset_rpl_t) / 8);
    return r;
  endfunction

  function automatic fpga_ignore_rpl_t get_fpga_ignore_rpl(header_t ignored);
    fpga_ignore_rpl_t r;
    r.hdr.cmd    = FPGA_IGNORE_RPL;
    r.hdr.len    = 32'($bits(fpga_ignore_rpl_t) / 8);
    r.ignore_hdr = ignored;
    return r;
  endfunction

  function automatic fpga_status_rpl_t get_fpga_status_rpl(logic [63:0] build_host,
                                                           logic [63:0] build_date,
                                                           fpga_state_t fpga_state);
    fpga_status_rpl_t r;
    r.hdr.cmd    = FPGA_STATUS_RPL;
    r.hdr.len    = 32'($bits(fpga_status_rpl_t) / 8);
    r.version    = FPGA_VERSION;
    r.cmd_cap    = FPGA_CMD_CAP;
    r.build_host = build_host;
    r.build_date = build_date;
    r.fpga_state = fpga_state;
    return r;
  endfunction

  // Short or disabled commands are answered with an ignore reply.
  function automatic route_e get_route(header_t hdr);
    route_e r;
    r = RouteIgnore;
    if (hdr.len >= 32'd8) begin
      if (hdr.cmd == VERIFY_EQUIHASH &&
          (FPGA_CMD_CAP[ENB_VERIFY_EQUIHASH_200_9] || FPGA_CMD_CAP[ENB_VERIFY_EQUIHASH_144_5])) begin
        r = RouteEq;
      end else if (hdr.cmd == VERIFY_SECP256K1_SIG && FPGA_CMD_CAP[ENB_VERIFY_SECP256K1_SIG]) begin
        r = RouteSecp;
      end else if (hdr.cmd == RESET_FPGA) begin
        r = RouteReset;
      end else if (hdr.cmd == FPGA_STATUS) begin
        r = RouteStatus;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/zcash_rpl_serialiser.sv
// Wide register to 64-bit stream. A load captures RegWidth bits plus a byte length;
// words are then emitted LSB word first with sop on the first and eop on the last.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i, dat_i, len_i capture a reply (len_i in bytes, > 0)
//   dat_o/val_o/sop_o/eop_o/mod_o, rdy_i  output stream; mod_o = valid bytes on eop, 0 = 8
module zcash_rpl_serialiser
  import zcash_cmd_dispatch_pkg::*;
#(
  parameter int unsigned RegWidth = RplRegWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [RegWidth-1:0] dat_i,
  input  logic [15:0]         len_i,
  output logic [63:0]         dat_o,
  output logic                val_o,
  output logic                sop_o,
  output logic                eop_o,
  output logic [2:0]          mod_o,
  input  logic                rdy_i
);

  localparam int unsigned MaxWords = RegWidth / 64;
  localparam int unsigned CntW     = $clog2(MaxWords + 1);

  logic [RegWidth-1:0] dat_q, dat_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                first_q, first_d;
  logic [2:0]          mod_q, mod_d;

  assign val_o = (cnt_q != '0);
  assign eop_o = (cnt_q == CntW'(1));
  assign sop_o = first_q & val_o;
  assign dat_o = dat_q[63:0];
  assign mod_o = eop_o ? mod_q : 3'd0;

  always_comb begin
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    mod_d   = mod_q;
    if (load_i) begin
      dat_d   = dat_i;
      cnt_d   = CntW'((len_i + 16'd7) >> 3);
      first_d = 1'b1;
      mod_d   = len_i[2:0];
    end else if (val_o && rdy_i) begin
      dat_d   = dat_q >> 64;
      cnt_d   = cnt_q - CntW'(1);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      mod_q   <= 3'd0;
    end else begin
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      mod_q   <= mod_d;
    end
  end

endmodule

// File: rtl/zcash_cmd_dispatch.sv
// Host command front end. Parses the 8-byte header of each host packet, forwards
// verification commands whole to the equihash or secp256k1 engine, and answers
// RESET_FPGA / FPGA_STATUS / unrecognised commands with a locally built reply.
// Ports:
//   i_clk, i_rst_n                          clock, asynchronous active-low reset
//   i_rx_*, o_rx_rdy                        host input stream
//   o_eq_*, i_eq_rdy / o_secp_*, i_secp_rdy engine streams
//   o_rpl_*, i_rpl_rdy                      local reply stream (o_rpl_mod on last word)
//   i_fpga_state                            sampled when a status reply is built
//   o_reset_req                             one-cycle pulse after the reset reply is taken
//   o_err                                   sticky framing error
module zcash_cmd_dispatch
  import zcash_cmd_dispatch_pkg::*;
#(
  parameter logic [63:0] BUILD_HOST = 64'd0,
  parameter logic [63:0] BUILD_DATE = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_rx_dat,
  input  logic        i_rx_val,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  output logic        o_rx_rdy,
  output logic [63:0] o_eq_dat,
  output logic        o_eq_val,
  output logic        o_eq_sop,
  output logic        o_eq_eop,
  input  logic        i_eq_rdy,
  output logic [63:0] o_secp_dat,
  output logic        o_secp_val,
  output logic        o_secp_sop,
  output logic        o_secp_eop,
  input  logic        i_secp_rdy,
  output logic [63:0] o_rpl_dat,
  output logic        o_rpl_val,
  output logic        o_rpl_sop,
  output logic        o_rpl_eop,
  output logic [2:0]  o_rpl_mod,
  input  logic        i_rpl_rdy,
  input  logic [7:0]  i_fpga_state,
  output logic        o_reset_req,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StIdle,
    StFwdEq,
    StFwdSecp,
    StDrain,
    StRpl
  } state_e;

  state_e  state_q, state_d;
  header_t hdr_q, hdr_d;
  logic    hdr_pend_q, hdr_pend_d;  // captured header not yet taken by the engine
  logic    hdr_eop_q, hdr_eop_d;    // header word was the whole packet
  logic    err_q, err_d;
  logic    rst_rpl_q, rst_rpl_d;    // reply in flight is the reset reply
  logic    reset_req_q, reset_req_d;

  logic                   rx_rdy, rx_acc;
  header_t                hdr_src;
  route_e                 route;
  logic [RplRegWidth-1:0] rpl_reg;
  logic [15:0]            rpl_len;
  logic                   rpl_load;
  logic                   rpl_val, rpl_eop;
  logic [63:0]            fwd_dat;
  logic                   fwd_val, fwd_sop, fwd_eop, fwd_rdy;

  // Held low while reset is asserted, high as soon as it is released in IDLE.
  assign o_rx_rdy = rx_rdy & i_rst_n;
  assign rx_acc   = i_rx_val & o_rx_rdy;
  assign fwd_rdy  = (state_q == StFwdEq) ? i_eq_rdy : i_secp_rdy;

  always_comb begin
    rx_rdy = 1'b0;
    case (state_q)
      StIdle, StDrain: rx_rdy = 1'b1;
      StFwdEq:         rx_rdy = !hdr_pend_q && i_eq_rdy;
      StFwdSecp:       rx_rdy = !hdr_pend_q && i_secp_rdy;
      default:         rx_rdy = 1'b0;
    endcase
  end

  // In IDLE the header is still on the input bus; after a drain it is in hdr_q.
  assign hdr_src = (state_q == StIdle) ? header_t'(i_rx_dat) : hdr_q;
  assign route   = get_route(hdr_src);

  always_comb begin
    rpl_reg = '0;
    rpl_len = 16'd0;
    case (route)
      RouteReset: begin
        rpl_reg[$bits(fpga_reset_rpl_t)-1:0] = get_fpga_reset_rpl();
        rpl_len = 16'($bits(fpga_reset_rpl_t) / 8);
      end
      RouteStatus: begin
        rpl_reg[$bits(fpga_status_rpl_t)-1:0] =
            get_fpga_status_rpl(BUILD_HOST, BUILD_DATE, i_fpga_state);
        rpl_len = 16'($bits(fpga_status_rpl_t) / 8);
      end
      default: begin
        rpl_reg[$bits(fpga_ignore_rpl_t)-1:0] = get_fpga_ignore_rpl(hdr_src);
        rpl_len = 16'($bits(fpga_ignore_rpl_t) / 8);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_pend_d  = hdr_pend_q;
    hdr_eop_d   = hdr_eop_q;
    err_d       = err_q;
    rst_rpl_d   = rst_rpl_q;
    reset_req_d = 1'b0;
    rpl_load    = 1'b0;
    fwd_dat     = i_rx_dat;
    fwd_val     = 1'b0;
    fwd_sop     = 1'b0;
    fwd_eop     = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_acc) begin
          if (!i_rx_sop) begin
            err_d = 1'b1;
          end else begin
            hdr_d      = header_t'(i_rx_dat);
            hdr_eop_d  = i_rx_eop;
            hdr_pend_d = 1'b1;
            case (route)
              RouteEq:   state_d = StFwdEq;
              RouteSecp: state_d = StFwdSecp;
              default: begin
                if (i_rx_eop) begin
                  state_d   = StRpl;
                  rpl_load  = 1'b1;
                  rst_rpl_d = (route == RouteReset);
                end else begin
                  state_d = StDrain;
                end
              end
            endcase
          end
        end
      end

      StFwdEq, StFwdSecp: begin
        if (hdr_pend_q) begin
          fwd_dat = hdr_q;
          fwd_val = 1'b1;
          fwd_sop = 1'b1;
          fwd_eop = hdr_eop_q;
          if (fwd_rdy) begin
            hdr_pend_d = 1'b0;
            if (hdr_eop_q) state_d = StIdle;
          end
        end else begin
          // Payload passes straight through; a stray sop is kept as data.
          fwd_val = i_rx_val;
          fwd_eop = i_rx_eop;
          if (rx_acc) begin
            if (i_rx_sop) err_d = 1'b1;
            if (i_rx_eop) state_d = StIdle;
          end
        end
      end

      StDrain: begin
        if (rx_acc) begin
          if (i_rx_sop) err_d = 1'b1;
          if (i_rx_eop) begin
            state_d   = StRpl;
            rpl_load  = 1'b1;
            rst_rpl_d = (route == RouteReset);
          end
        end
      end

      StRpl: begin
        if (rpl_val && rpl_eop && i_rpl_rdy) begin
          state_d     = StIdle;
          reset_req_d = rst_rpl_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign o_eq_dat   = fwd_dat;
  assign o_eq_val   = fwd_val & (state_q == StFwdEq);
  assign o_eq_sop   = fwd_sop & (state_q == StFwdEq);
  assign o_eq_eop   = fwd_eop & (state_q == StFwdEq);
  assign o_secp_dat = fwd_dat;
  assign o_secp_val = fwd_val & (state_q == StFwdSecp);
  assign o_secp_sop = fwd_sop & (state_q == StFwdSecp);
  assign o_secp_eop = fwd_eop & (state_q == StFwdSecp);

  assign o_rpl_val   = rpl_val;
  assign o_rpl_eop   = rpl_eop;
  assign o_reset_req = reset_req_q;
  assign o_err       = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      hdr_q       <= '0;
      hdr_pend_q  <= 1'b0;
      hdr_eop_q   <= 1'b0;
      err_q       <= 1'b0;
      rst_rpl_q   <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_pend_q  <= hdr_pend_d;
      hdr_eop_q   <= hdr_eop_d;
      err_q       <= err_d;
      rst_rpl_q   <= rst_rpl_d;
      reset_req_q <= reset_req_d;
    end
  end

  zcash_rpl_serialiser #(
    .RegWidth(RplRegWidth)
  ) u_rpl_ser (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .load_i(rpl_load),
    .dat_i (rpl_reg),
    .len_i (rpl_len),
    .dat_o (o_rpl_dat),
    .val_o (rpl_val),
    .sop_o (o_rpl_sop),
    .eop_o (rpl_eop),
    .mod_o (o_rpl_mod),
    .rdy_i (i_rpl_rdy)
  );

endmodule

// File: tb/tb_zcash_cmd_dispatch.sv
module tb_zcash_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rx_dat = '0;
  logic        rx_val = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
  logic        rx_rdy;
  logic [63:0] eq_dat, secp_dat, rpl_dat;
  logic        eq_val, eq_sop, eq_eop;
  logic        secp_val, secp_sop, secp_eop;
  logic        rpl_val, rpl_sop, rpl_eop;
  logic [2:0]  rpl_mod;
  logic        eq_rdy = 1'b0, secp_rdy = 1'b0, rpl_rdy = 1'b0;
  logic [7:0]  fpga_state = '0;
  logic        reset_req, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zcash_cmd_dispatch #(
    .BUILD_HOST(64'h1111_2222_3333_4444),
    .BUILD_DATE(64'h5555_6666_7777_8888)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_dat    (rx_dat),
    .i_rx_val    (rx_val),
    .i_rx_sop    (rx_sop),
    .i_rx_eop    (rx_eop),
    .o_rx_rdy    (rx_rdy),
    .o_eq_dat    (eq_dat),
    .o_eq_val    (eq_val),
    .o_eq_sop    (eq_sop),
    .o_eq_eop    (eq_eop),
    .i_eq_rdy    (eq_rdy),
    .o_secp_dat  (secp_dat),
    .o_secp_val  (secp_val),
    .o_secp_sop  (secp_sop),
    .o_secp_eop  (secp_eop),
    .i_secp_rdy  (secp_rdy),
    .o_rpl_dat   (rpl_dat),
    .o_rpl_val   (rpl_val),
    .o_rpl_sop   (rpl_sop),
    .o_rpl_eop   (rpl_eop),
    .o_rpl_mod   (rpl_mod),
    .i_rpl_rdy   (rpl_rdy),
    .i_fpga_state(fpga_state),
    .o_reset_req (reset_req),
    .o_err       (err)
  );

  // Drive one input word at a negedge; it is accepted at the following posedge.
  task automatic drive(input logic [63:0] d, input logic v, input logic s, input logic e);
    rx_dat = d;
    rx_val = v;
    rx_sop = s;
    rx_eop = e;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rx_rdy, eq_val, secp_val, rpl_val, reset_req, err, rpl_mod} !== 9'd0) begin
      errors++;
      $display("FAIL reset_values: got %b want 0", {rx_rdy, eq_val, secp_val, rpl_val,
                                                    reset_req, err, rpl_mod});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset: got %b want 1", rx_rdy);
    end
  endtask

  task automatic test_status();
    logic [63:0] exp [5];
    exp[0] = 64'h80000001_00000025;
    exp[1] = 64'h00000103_00010201;
    exp[2] = 64'h33334444_00000000;
    exp[3] = 64'h77778888_11112222;
    exp[4] = 64'h0000005A_55556666;
    @(negedge clk);
    rpl_rdy    = 1'b1;
    fpga_state = 8'h5A;
    drive({32'h1, 32'd8}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    fpga_state = 8'hC3;  // must not leak into the reply
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rpl_val !== 1'b1 || rpl_dat !== exp[i] || rpl_sop !== (i == 0) ||
          rpl_eop !== (i == 4) || rpl_mod !== ((i == 4) ? 3'd5 : 3'd0)) begin
        errors++;
        $display("FAIL status_word%0d: got val=%b dat=%h sop=%b eop=%b mod=%0d want dat=%h",
                 i, rpl_val, rpl_dat, rpl_sop, rpl_eop, rpl_mod, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if (rx_rdy !== 1'b0) begin
          errors++;
          $display("FAIL status_rx_rdy: got %b want 0", rx_rdy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (rpl_val !== 1'b0 || rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL status_end: got val=%b rdy=%b want 0 1", rpl_val, rx_rdy);
    end
  endtask

  task automatic test_secp_fwd();
    logic [63:0] exp [26];
    int n_in, n_out, cyc;
    logic acc_in, acc_out;
    for (int k = 0; k < 26; k++)
      exp[k] = (k == 0) ? {32'h101, 32'd208} : {32'hC0DE0000 + 32'(k), 32'(k * 7)};
    n_in  = 0;
    n_out = 0;
    cyc   = 0;
    while (n_out < 26 && cyc < 400) begin
      @(negedge clk);
      secp_rdy = 1'($urandom_range(0, 1));
      drive(exp[(n_in < 26) ? n_in : 25], n_in < 26, n_in == 0, n_in == 25);
      #1;
      acc_in  = rx_val && rx_rdy;
      acc_out = secp_val && secp_rdy;
      if (acc_out) begin
        checks++;
        if (secp_dat !== exp[n_out] || secp_sop !== (n_out == 0) ||
            secp_eop !== (n_out == 25)) begin
          errors++;
          $display("FAIL secp_word%0d: got dat=%h sop=%b eop=%b want %h", n_out, secp_dat,
                   secp_sop, secp_eop, exp[n_out]);
        end
        n_out++;
      end
      if (acc_in) n_in++;
      cyc++;
    end
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    secp_rdy = 1'b0;
    checks++;
    if (n_out != 26 || n_in != 26) begin
      errors++;
      $display("FAIL secp_count: got out=%0d in=%0d want 26 26", n_out, n_in);
    end
    checks++;
    if (secp_val !== 1'b0 || rx_rdy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL secp_end: got val=%b rdy=%b err=%b want 0 1 0", secp_val, rx_rdy, err);
    end
  endtask

  task automatic test_eq_single();
    @(negedge clk);
    eq_rdy = 1'b1;
    drive({32'h100, 32'd8}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({eq_val, eq_sop, eq_eop, rx_rdy} !== 4'b1110 || eq_dat !== {32'h100, 32'd8}) begin
      errors++;
      $display("FAIL eq_single: got val/sop/eop/rdy=%b dat=%h want 1110 %h",
               {eq_val, eq_sop, eq_eop, rx_rdy}, eq_dat, {32'h100, 32'd8});
    end
    @(negedge clk);
    checks++;
    if (eq_val !== 1'b0 || rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL eq_single_end: got val=%b rdy=%b want 0 1", eq_val, rx_rdy);
    end
    eq_rdy = 1'b0;
  endtask

  task automatic test_reset_cmd();
    @(negedge clk);
    rpl_rdy = 1'b0;
    drive({32'h0, 32'd8}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rpl_val !== 1'b1 || rpl_dat !== 64'h80000000_00000008 || rpl_sop !== 1'b1 ||
        rpl_eop !== 1'b1 || rpl_mod !== 3'd0) begin
      errors++;
      $display("FAIL reset_rpl: got val=%b dat=%h sop=%b eop=%b mod=%0d want %h",
               rpl_val, rpl_dat, rpl_sop, rpl_eop, rpl_mod, 64'h80000000_00000008);
    end
    @(negedge clk);
    checks++;
    if (rpl_val !== 1'b1 || rpl_dat !== 64'h80000000_00000008 || reset_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_rpl_hold: got val=%b dat=%h req=%b", rpl_val, rpl_dat, reset_req);
    end
    rpl_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (reset_req !== 1'b1 || rpl_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_pulse: got req=%b val=%b want 1 0", reset_req, rpl_val);
    end
    @(negedge clk);
    checks++;
    if (reset_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_width: got %b want 0", reset_req);
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    rpl_rdy = 1'b1;
    drive({32'h203, 32'd24}, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(64'hDEAD, 1'b1, 1'b0, 1'b0);
    checks++;
    if (rpl_val !== 1'b0 || rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL drain_state: got val=%b rdy=%b want 0 1", rpl_val, rx_rdy);
    end
    @(negedge clk);
    drive(64'hBEEF, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rpl_val !== 1'b1 || rpl_dat !== 64'h80000002_00000010 || rpl_sop !== 1'b1 ||
        rpl_eop !== 1'b0) begin
      errors++;
      $display("FAIL ignore_w0: got val=%b dat=%h sop=%b eop=%b want %h", rpl_val, rpl_dat,
               rpl_sop, rpl_eop, 64'h80000002_00000010);
    end
    @(negedge clk);
    checks++;
    if (rpl_val !== 1'b1 || rpl_dat !== 64'h00000203_00000018 || rpl_eop !== 1'b1 ||
        rpl_mod !== 3'd0) begin
      errors++;
      $display("FAIL ignore_w1: got val=%b dat=%h eop=%b mod=%0d want %h", rpl_val, rpl_dat,
               rpl_eop, rpl_mod, 64'h00000203_00000018);
    end
    @(negedge clk);
    // Short length on an otherwise enabled command.
    drive({32'h100, 32'd4}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rpl_val !== 1'b1 || rpl_dat !== 64'h80000002_00000010 || eq_val !== 1'b0) begin
      errors++;
      $display("FAIL short_w0: got val=%b dat=%h eq_val=%b", rpl_val, rpl_dat, eq_val);
    end
    @(negedge clk);
    checks++;
    if (rpl_dat !== 64'h00000100_00000004 || rpl_eop !== 1'b1) begin
      errors++;
      $display("FAIL short_w1: got dat=%h eop=%b want %h", rpl_dat, rpl_eop,
               64'h00000100_00000004);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b want 0", err);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    drive(64'h1234, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || rpl_val !== 1'b0) begin
      errors++;
      $display("FAIL err_no_sop: got err=%b val=%b want 1 0", err, rpl_val);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %b want 0", err);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    secp_rdy = 1'b1;
    drive({32'h101, 32'd24}, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(64'h1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (rx_rdy !== 1'b0 || secp_sop !== 1'b1 || secp_dat !== {32'h101, 32'd24}) begin
      errors++;
      $display("FAIL fwd_hdr: got rdy=%b sop=%b dat=%h", rx_rdy, secp_sop, secp_dat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (secp_val !== 1'b1 || secp_sop !== 1'b0 || secp_dat !== 64'h1 || err !== 1'b0) begin
      errors++;
      $display("FAIL fwd_stray_sop: got val=%b sop=%b dat=%h err=%b", secp_val, secp_sop,
               secp_dat, err);
    end
    @(negedge clk);
    drive(64'h2, 1'b1, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_mid_fwd: got %b want 1", err);
    end
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || secp_val !== 1'b0 || rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL err_fwd_end: got err=%b val=%b rdy=%b", err, secp_val, rx_rdy);
    end
    secp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp [5];
    exp[0] = 64'h80000001_00000025;
    exp[1] = 64'h00000103_00010201;
    exp[2] = 64'h33334444_00000000;
    exp[3] = 64'h77778888_11112222;
    exp[4] = 64'h00000011_55556666;
    @(negedge clk);
    rpl_rdy    = 1'b1;
    fpga_state = 8'h77;
    drive({32'h1, 32'd8}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rpl_val !== 1'b0 || rx_rdy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got val=%b rdy=%b err=%b want 0 0 0", rpl_val, rx_rdy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rpl_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_rpl: got %b want 0", rpl_val);
    end
    fpga_state = 8'h11;
    drive({32'h1, 32'd8}, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rpl_val !== 1'b1 || rpl_dat !== exp[i] || rpl_eop !== (i == 4)) begin
        errors++;
        $display("FAIL restatus_word%0d: got val=%b dat=%h eop=%b want %h", i, rpl_val,
                 rpl_dat, rpl_eop, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (rpl_val !== 1'b0) begin
      errors++;
      $display("FAIL restatus_end: got %b want 0", rpl_val);
    end
  endtask

  initial begin
    test_reset();
    test_status();
    test_secp_fwd();
    test_eq_single();
    test_reset_cmd();
    test_ignore();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
